bp_axil_arbiter_2to1: RTL and testbench
=======================================

Name: bp_axil_arbiter_2to1

Overview:
Merges the two AXI4-Lite master ports of the BP lite top (port 0 = I$ path, port 1 = D$ path) onto a single AXI4-Lite master, so the core can attach to one slave (e.g. a Zynq GP port). Read and write directions are arbitrated independently with round-robin priority. Each direction has at most one outstanding transaction. Responses are routed back to the granted port.

Parameters:
axil_addr_width_p, 32, AXI-Lite address width
axil_data_width_p, 64, AXI-Lite data width; must equal the BP UCE fill width
axil_mask_width_lp, axil_data_width_p>>3, write strobe width (localparam)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axil_aw{addr_i,prot_i,valid_i}/awready_o  in/out  [1:0]x{addr,3,1}/[1:0]  AW channels from the two upstream masters
- s_axil_w{data_i,strb_i,valid_i}/wready_o  in/out  [1:0]x{data,mask,1}/[1:0]  W channels from the upstream masters
- s_axil_b{resp_o,valid_o}/bready_i  out/in  [1:0]x{2,1}/[1:0]  B channels to the upstream masters
- s_axil_ar{addr_i,prot_i,valid_i}/arready_o  in/out  [1:0]x{addr,3,1}/[1:0]  AR channels from the upstream masters
- s_axil_r{data_o,resp_o,valid_o}/rready_i  out/in  [1:0]x{data,2,1}/[1:0]  R channels to the upstream masters
- m_axil_aw{addr_o,prot_o,valid_o}/awready_i  out/in  addr,3,1/1  merged AW
- m_axil_w{data_o,strb_o,valid_o}/wready_i  out/in  data,mask,1/1  merged W
- m_axil_b{resp_i,valid_i}/bready_o  in/out  2,1/1  merged B
- m_axil_ar{addr_o,prot_o,valid_o}/arready_i  out/in  addr,3,1/1  merged AR
- m_axil_r{data_i,resp_i,valid_i}/rready_o  in/out  data,2,1/1  merged R

Behaviour:
Write FSM states: W_IDLE, W_REQ, W_RESP.
- W_IDLE: no s-side ready and no m-side valid. If any s_awvalid is set, the round-robin arbiter picks a grant and registers wgnt. The port not last granted wins a tie. Go to W_REQ next cycle, so arbitration costs 1 cycle.
- W_REQ: the AW and W channels of port wgnt pass through combinationally. m_awvalid_o = s_awvalid[wgnt] & ~aw_done; same pattern for W. s_awready[wgnt] = m_awready_i & ~aw_done; same pattern for W.
- W_REQ: aw_done and w_done are set on their respective handshakes; AW and W may complete in either order or in the same cycle. When both are done (including same-cycle completion), go to W_RESP and clear both flags.
- W_RESP: m_bready_o = s_bready[wgnt]; s_bvalid[wgnt] = m_bvalid_i; resp is forwarded unchanged. On the B handshake, set wlast <= wgnt and return to W_IDLE.
- The non-granted port sees all readies and valids at 0 at all times.

Read FSM states: R_IDLE, R_ADDR, R_DATA.
- Arbitration on s_arvalid is identical to the write side and uses a separate rlast.
- R_ADDR: AR of port rgnt passes through; on the AR handshake go to R_DATA.
- R_DATA: R is routed to rgnt; on the R handshake, set rlast <= rgnt and return to R_IDLE.

General rules:
- Reset: FSMs go to IDLE, done flags clear, wlast = rlast = 1 (so port 0 wins first). All *valid_o and *ready_o are 0 during reset and in the first cycle after it.
- Reset mid-transaction abandons the transaction. No synthetic B/R responses are generated.
- Read and write proceed concurrently with no ordering between them; upstream BP already serializes per port.
- A grant is held until its response completes; an upstream valid dropping in W_REQ/R_ADDR is an AXI protocol violation and is not handled.
- Response payloads (resp, data) are muxed by grant. Output values while valid=0 are don't-care but are driven 0.
- Sustained throughput is one transaction per direction per 3 cycles minimum (IDLE, REQ, RESP with zero-wait slave).
- Elaboration $error if axil_data_width_p is not 32 or 64.

Decomposition:
- Shared package: FSM state enums (bp_axil_wstate_e, bp_axil_rstate_e) and AXI resp constants (e_axi_resp_okay=2'b00, slverr=2'b10).
- One sub-module bp_axil_rr_arb2: 2-input round-robin arbiter, combinational grant from (req[1:0], last). Instantiated twice.

Test Plan:
- Single read: port0 arvalid, addr 0x0010_0000; slave returns rdata 0xDEAD_BEEF_0123_4567 -> m_araddr_o = 0x0010_0000 one cycle after arvalid; s_rvalid[0] = 1 with that data; s_rvalid[1] never asserts.
- Simultaneous reads from both ports after reset -> port0 served first, then port1. In a second simultaneous round port0 is again served first (after port1 last), so grants alternate 0,1,0,1.
- Write with W arriving 3 cycles before AW (addr 0x8000_0040, strb 0xF0) -> exactly one m-side handshake each on AW and W; s_bvalid[1] carries bresp 2'b10 from the slave.
- Concurrent read on port0 and write on port1 with a zero-wait slave -> both complete, each in 3 cycles; no cross-routing of B/R.
- Slave stalls awready 10 cycles while port0 issues more requests -> no extra m_awvalid_o; the grant is held; s_awready[1] stays 0 throughout.
- Assert reset_i during W_RESP -> all outputs 0 the next cycle; the first post-reset write from port1 completes normally.

Source files
------------

// File: rtl/bp_axil_arbiter_2to1_pkg.sv
// Shared types and constants for the 2:1 AXI4-Lite arbiter.
package bp_axil_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } bp_axil_wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } bp_axil_rstate_e;

  localparam logic [1:0] e_axi_resp_okay   = 2'b00;
  localparam logic [1:0] e_axi_resp_slverr = 2'b10;

endpackage

// File: rtl/bp_axil_rr_arb2.sv
// Two-input round-robin arbiter: the port not granted last wins a tie.
module bp_axil_rr_arb2
  import bp_axil_arbiter_2to1_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Combinational grant selection
  always_comb begin
    valid_o = |req_i;
    gnt_o   = 1'b0;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bp_axil_arbiter_2to1.sv
// Merges two AXI4-Lite masters (port 0 = I$, port 1 = D$) onto one master.
// Read and write directions are arbitrated independently, round-robin,
// with at most one outstanding transaction per direction.
module bp_axil_arbiter_2to1
  import bp_axil_arbiter_2to1_pkg::*;
#(
  parameter int axil_addr_width_p  = 32,
  parameter int axil_data_width_p  = 64,
  localparam int axil_mask_width_lp = axil_data_width_p >> 3
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic [1:0][axil_addr_width_p-1:0]  s_axil_awaddr_i,
  input  logic [1:0][2:0]                    s_axil_awprot_i,
  input  logic [1:0]                         s_axil_awvalid_i,
  output logic [1:0]                         s_axil_awready_o,

  input  logic [1:0][axil_data_width_p-1:0]  s_axil_wdata_i,
  input  logic [1:0][axil_mask_width_lp-1:0] s_axil_wstrb_i,
  input  logic [1:0]                         s_axil_wvalid_i,
  output logic [1:0]                         s_axil_wready_o,

  output logic [1:0][1:0]                    s_axil_bresp_o,
  output logic [1:0]                         s_axil_bvalid_o,
  input  logic [1:0]                         s_axil_bready_i,

  input  logic [1:0][axil_addr_width_p-1:0]  s_axil_araddr_i,
  input  logic [1:0][2:0]                    s_axil_arprot_i,
  input  logic [1:0]                         s_axil_arvalid_i,
  output logic [1:0]                         s_axil_arready_o,

  output logic [1:0][axil_data_width_p-1:0]  s_axil_rdata_o,
  output logic [1:0][1:0]                    s_axil_rresp_o,
  output logic [1:0]                         s_axil_rvalid_o,
  input  logic [1:0]                         s_axil_rready_i,

  output logic [axil_addr_width_p-1:0]       m_axil_awaddr_o,
  output logic [2:0]                         m_axil_awprot_o,
  output logic                               m_axil_awvalid_o,
  input  logic                               m_axil_awready_i,

  output logic [axil_data_width_p-1:0]       m_axil_wdata_o,
  output logic [axil_mask_width_lp-1:0]      m_axil_wstrb_o,
  output logic                               m_axil_wvalid_o,
  input  logic                               m_axil_wready_i,

  input  logic [1:0]                         m_axil_bresp_i,
  input  logic                               m_axil_bvalid_i,
  output logic                               m_axil_bready_o,

  output logic [axil_addr_width_p-1:0]       m_axil_araddr_o,
  output logic [2:0]                         m_axil_arprot_o,
  output logic                               m_axil_arvalid_o,
  input  logic                               m_axil_arready_i,

  input  logic [axil_data_width_p-1:0]       m_axil_rdata_i,
  input  logic [1:0]                         m_axil_rresp_i,
  input  logic                               m_axil_rvalid_i,
  output logic                               m_axil_rready_o
);

  if (axil_data_width_p != 32 && axil_data_width_p != 64) begin : g_width_check
    $error("bp_axil_arbiter_2to1: axil_data_width_p must be 32 or 64");
  end

  bp_axil_wstate_e wstate_q, wstate_d;
  bp_axil_rstate_e rstate_q, rstate_d;
  logic wgnt_q, wgnt_d, wlast_q, wlast_d;
  logic rgnt_q, rgnt_d, rlast_q, rlast_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic warb_gnt, warb_valid, rarb_gnt, rarb_valid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  bp_axil_rr_arb2 u_warb (
    .req_i   (s_axil_awvalid_i),
    .last_i  (wlast_q),
    .gnt_o   (warb_gnt),
    .valid_o (warb_valid)
  );

  bp_axil_rr_arb2 u_rarb (
    .req_i   (s_axil_arvalid_i),
    .last_i  (rlast_q),
    .gnt_o   (rarb_gnt),
    .valid_o (rarb_valid)
  );

  assign aw_hs = m_axil_awvalid_o & m_axil_awready_i;
  assign w_hs  = m_axil_wvalid_o  & m_axil_wready_i;
  assign b_hs  = m_axil_bvalid_i  & m_axil_bready_o;
  assign ar_hs = m_axil_arvalid_o & m_axil_arready_i;
  assign r_hs  = m_axil_rvalid_i  & m_axil_rready_o;

  // Write-side channel routing; everything is held at 0 while in reset
  always_comb begin
    s_axil_awready_o = '0;
    s_axil_wready_o  = '0;
    s_axil_bvalid_o  = '0;
    s_axil_bresp_o   = '0;
    m_axil_awaddr_o  = '0;
    m_axil_awprot_o  = '0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wdata_o   = '0;
    m_axil_wstrb_o   = '0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    if (!reset_i) begin
      case (wstate_q)
        W_REQ: begin
          m_axil_awvalid_o = s_axil_awvalid_i[wgnt_q] & ~aw_done_q;
          if (s_axil_awvalid_i[wgnt_q] & ~aw_done_q) begin
            m_axil_awaddr_o = s_axil_awaddr_i[wgnt_q];
            m_axil_awprot_o = s_axil_awprot_i[wgnt_q];
          end
          s_axil_awready_o[wgnt_q] = m_axil_awready_i & ~aw_done_q;
          m_axil_wvalid_o = s_axil_wvalid_i[wgnt_q] & ~w_done_q;
          if (s_axil_wvalid_i[wgnt_q] & ~w_done_q) begin
            m_axil_wdata_o = s_axil_wdata_i[wgnt_q];
            m_axil_wstrb_o = s_axil_wstrb_i[wgnt_q];
          end
          s_axil_wready_o[wgnt_q] = m_axil_wready_i & ~w_done_q;
        end
        W_RESP: begin
          m_axil_bready_o         = s_axil_bready_i[wgnt_q];
          s_axil_bvalid_o[wgnt_q] = m_axil_bvalid_i;
          s_axil_bresp_o[wgnt_q]  = m_axil_bvalid_i ? m_axil_bresp_i : e_axi_resp_okay;
        end
        default: ;
      endcase
    end
  end

  // Write FSM next state: AW and W may complete in either order
  always_comb begin
    wstate_d  = wstate_q;
    wgnt_d    = wgnt_q;
    wlast_d   = wlast_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wstate_q)
      W_IDLE: begin
        if (warb_valid) begin
          wgnt_d   = warb_gnt;
          wstate_d = W_REQ;
        end
      end
      W_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          wstate_d  = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wlast_d  = wgnt_q;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wstate_q  <= W_IDLE;
      wgnt_q    <= 1'b0;
      wlast_q   <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      wgnt_q    <= wgnt_d;
      wlast_q   <= wlast_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read-side channel routing; everything is held at 0 while in reset
  always_comb begin
    s_axil_arready_o = '0;
    s_axil_rvalid_o  = '0;
    s_axil_rdata_o   = '0;
    s_axil_rresp_o   = '0;
    m_axil_araddr_o  = '0;
    m_axil_arprot_o  = '0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    if (!reset_i) begin
      case (rstate_q)
        R_ADDR: begin
          m_axil_arvalid_o = s_axil_arvalid_i[rgnt_q];
          if (s_axil_arvalid_i[rgnt_q]) begin
            m_axil_araddr_o = s_axil_araddr_i[rgnt_q];
            m_axil_arprot_o = s_axil_arprot_i[rgnt_q];
          end
          s_axil_arready_o[rgnt_q] = m_axil_arready_i;
        end
        R_DATA: begin
          m_axil_rready_o         = s_axil_rready_i[rgnt_q];
          s_axil_rvalid_o[rgnt_q] = m_axil_rvalid_i;
          if (m_axil_rvalid_i) begin
            s_axil_rdata_o[rgnt_q] = m_axil_rdata_i;
            s_axil_rresp_o[rgnt_q] = m_axil_rresp_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Read FSM next state
  always_comb begin
    rstate_d = rstate_q;
    rgnt_d   = rgnt_q;
    rlast_d  = rlast_q;
    case (rstate_q)
      R_IDLE: begin
        if (rarb_valid) begin
          rgnt_d   = rarb_gnt;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_hs) rstate_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          rlast_d  = rgnt_q;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rstate_q <= R_IDLE;
      rgnt_q   <= 1'b0;
      rlast_q  <= 1'b1;
    end else begin
      rstate_q <= rstate_d;
      rgnt_q   <= rgnt_d;
      rlast_q  <= rlast_d;
    end
  end

endmodule

// File: tb/tb_bp_axil_arbiter_2to1.sv
// Directed self-checking bench for bp_axil_arbiter_2to1.
module tb_bp_axil_arbiter_2to1;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW >> 3;

  logic clk = 1'b0;
  logic reset_i;

  logic [1:0][AW-1:0] s_axil_awaddr_i;
  logic [1:0][2:0]    s_axil_awprot_i;
  logic [1:0]         s_axil_awvalid_i;
  logic [1:0]         s_axil_awready_o;
  logic [1:0][DW-1:0] s_axil_wdata_i;
  logic [1:0][MW-1:0] s_axil_wstrb_i;
  logic [1:0]         s_axil_wvalid_i;
  logic [1:0]         s_axil_wready_o;
  logic [1:0][1:0]    s_axil_bresp_o;
  logic [1:0]         s_axil_bvalid_o;
  logic [1:0]         s_axil_bready_i;
  logic [1:0][AW-1:0] s_axil_araddr_i;
  logic [1:0][2:0]    s_axil_arprot_i;
  logic [1:0]         s_axil_arvalid_i;
  logic [1:0]         s_axil_arready_o;
  logic [1:0][DW-1:0] s_axil_rdata_o;
  logic [1:0][1:0]    s_axil_rresp_o;
  logic [1:0]         s_axil_rvalid_o;
  logic [1:0]         s_axil_rready_i;

  logic [AW-1:0] m_axil_awaddr_o;
  logic [2:0]    m_axil_awprot_o;
  logic          m_axil_awvalid_o;
  logic          m_axil_awready_i;
  logic [DW-1:0] m_axil_wdata_o;
  logic [MW-1:0] m_axil_wstrb_o;
  logic          m_axil_wvalid_o;
  logic          m_axil_wready_i;
  logic [1:0]    m_axil_bresp_i;
  logic          m_axil_bvalid_i;
  logic          m_axil_bready_o;
  logic [AW-1:0] m_axil_araddr_o;
  logic [2:0]    m_axil_arprot_o;
  logic          m_axil_arvalid_o;
  logic          m_axil_arready_i;
  logic [DW-1:0] m_axil_rdata_i;
  logic [1:0]    m_axil_rresp_i;
  logic          m_axil_rvalid_i;
  logic          m_axil_rready_o;

  int n_pass  = 0;
  int n_total = 0;
  int aw_cnt  = 0;
  int w_cnt   = 0;

  bp_axil_arbiter_2to1 #(
    .axil_addr_width_p (AW),
    .axil_data_width_p (DW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .s_axil_awaddr_i  (s_axil_awaddr_i),
    .s_axil_awprot_i  (s_axil_awprot_i),
    .s_axil_awvalid_i (s_axil_awvalid_i),
    .s_axil_awready_o (s_axil_awready_o),
    .s_axil_wdata_i   (s_axil_wdata_i),
    .s_axil_wstrb_i   (s_axil_wstrb_i),
    .s_axil_wvalid_i  (s_axil_wvalid_i),
    .s_axil_wready_o  (s_axil_wready_o),
    .s_axil_bresp_o   (s_axil_bresp_o),
    .s_axil_bvalid_o  (s_axil_bvalid_o),
    .s_axil_bready_i  (s_axil_bready_i),
    .s_axil_araddr_i  (s_axil_araddr_i),
    .s_axil_arprot_i  (s_axil_arprot_i),
    .s_axil_arvalid_i (s_axil_arvalid_i),
    .s_axil_arready_o (s_axil_arready_o),
    .s_axil_rdata_o   (s_axil_rdata_o),
    .s_axil_rresp_o   (s_axil_rresp_o),
    .s_axil_rvalid_o  (s_axil_rvalid_o),
    .s_axil_rready_i  (s_axil_rready_i),
    .m_axil_awaddr_o  (m_axil_awaddr_o),
    .m_axil_awprot_o  (m_axil_awprot_o),
    .m_axil_awvalid_o (m_axil_awvalid_o),
    .m_axil_awready_i (m_axil_awready_i),
    .m_axil_wdata_o   (m_axil_wdata_o),
    .m_axil_wstrb_o   (m_axil_wstrb_o),
    .m_axil_wvalid_o  (m_axil_wvalid_o),
    .m_axil_wready_i  (m_axil_wready_i),
    .m_axil_bresp_i   (m_axil_bresp_i),
    .m_axil_bvalid_i  (m_axil_bvalid_i),
    .m_axil_bready_o  (m_axil_bready_o),
    .m_axil_araddr_o  (m_axil_araddr_o),
    .m_axil_arprot_o  (m_axil_arprot_o),
    .m_axil_arvalid_o (m_axil_arvalid_o),
    .m_axil_arready_i (m_axil_arready_i),
    .m_axil_rdata_i   (m_axil_rdata_i),
    .m_axil_rresp_i   (m_axil_rresp_i),
    .m_axil_rvalid_i  (m_axil_rvalid_i),
    .m_axil_rready_o  (m_axil_rready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] all_vr();
    return {s_axil_awready_o, s_axil_wready_o, s_axil_bvalid_o,
            s_axil_arready_o, s_axil_rvalid_o,
            m_axil_awvalid_o, m_axil_wvalid_o, m_axil_bready_o,
            m_axil_arvalid_o, m_axil_rready_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tally();
    if (m_axil_awvalid_o && m_axil_awready_i) aw_cnt++;
    if (m_axil_wvalid_o && m_axil_wready_i) w_cnt++;
  endtask

  task automatic clear_inputs();
    s_axil_awaddr_i  = '0; s_axil_awprot_i = '0; s_axil_awvalid_i = '0;
    s_axil_wdata_i   = '0; s_axil_wstrb_i  = '0; s_axil_wvalid_i  = '0;
    s_axil_bready_i  = '0;
    s_axil_araddr_i  = '0; s_axil_arprot_i = '0; s_axil_arvalid_i = '0;
    s_axil_rready_i  = '0;
    m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0;
    m_axil_bresp_i   = '0;   m_axil_bvalid_i = 1'b0;
    m_axil_arready_i = 1'b0;
    m_axil_rdata_i   = '0;   m_axil_rresp_i  = '0; m_axil_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_inputs();
    repeat (3) cyc();
    settle();
    chk("reset_all_zero", 64'(all_vr()), 64'd0);
    cyc();
    reset_i = 1'b0;
    settle();
    chk("post_reset_all_zero", 64'(all_vr()), 64'd0);
  endtask

  logic [1:0] arr_exp [12];
  logic [1:0] rv_exp  [12];

  initial begin
    arr_exp = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    rv_exp  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    do_reset();

    // ---- single read on port 0
    cyc();
    s_axil_arvalid_i   = 2'b01;
    s_axil_araddr_i[0] = 32'h0010_0000;
    settle();
    chk("rd1_idle_arvalid", m_axil_arvalid_o, 1'b0);
    cyc();
    settle();
    chk("rd1_arvalid", m_axil_arvalid_o, 1'b1);
    chk("rd1_araddr", m_axil_araddr_o, 32'h0010_0000);
    chk("rd1_arready_stalled", s_axil_arready_o, 2'b00);
    m_axil_arready_i = 1'b1;
    settle();
    chk("rd1_arready", s_axil_arready_o, 2'b01);
    cyc();
    s_axil_arvalid_i = 2'b00;
    m_axil_arready_i = 1'b0;
    m_axil_rvalid_i  = 1'b1;
    m_axil_rdata_i   = 64'hDEAD_BEEF_0123_4567;
    s_axil_rready_i  = 2'b01;
    settle();
    chk("rd1_rvalid", s_axil_rvalid_o, 2'b01);
    chk("rd1_rdata0", s_axil_rdata_o[0], 64'hDEAD_BEEF_0123_4567);
    chk("rd1_rdata1_zero", s_axil_rdata_o[1], 64'd0);
    chk("rd1_rready", m_axil_rready_o, 1'b1);
    cyc();
    m_axil_rvalid_i = 1'b0;
    s_axil_rready_i = 2'b00;
    settle();
    chk("rd1_done_all_zero", 64'(all_vr()), 64'd0);

    // ---- simultaneous reads, zero-wait slave: grants 0,1,0,1
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc();
      s_axil_arvalid_i = 2'b11;
      s_axil_araddr_i[0] = 32'h0000_1000;
      s_axil_araddr_i[1] = 32'h0000_2000;
      m_axil_arready_i = 1'b1;
      m_axil_rvalid_i  = 1'b1;
      m_axil_rdata_i   = 64'h100 + 64'(k);
      s_axil_rready_i  = 2'b11;
      settle();
      chk($sformatf("rr_arready_k%0d", k), s_axil_arready_o, arr_exp[k]);
      chk($sformatf("rr_rvalid_k%0d", k), s_axil_rvalid_o, rv_exp[k]);
      if (rv_exp[k] == 2'b01) chk($sformatf("rr_rdata0_k%0d", k), s_axil_rdata_o[0], 64'h100 + 64'(k));
      if (rv_exp[k] == 2'b10) chk($sformatf("rr_rdata1_k%0d", k), s_axil_rdata_o[1], 64'h100 + 64'(k));
    end
    cyc();
    clear_inputs();
    settle();
    chk("rr_done_all_zero", 64'(all_vr()), 64'd0);

    // ---- write on port 1, W three cycles ahead of AW, SLVERR response
    aw_cnt = 0;
    w_cnt  = 0;
    cyc();
    s_axil_wvalid_i   = 2'b10;
    s_axil_wdata_i[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    s_axil_wstrb_i[1] = 8'hF0;
    m_axil_awready_i  = 1'b1;
    m_axil_wready_i   = 1'b1;
    settle();
    tally();
    chk("wr_early_wready", s_axil_wready_o, 2'b00);
    cyc(); settle(); tally();
    cyc(); settle(); tally();
    chk("wr_early_m_wvalid", m_axil_wvalid_o, 1'b0);
    cyc();
    s_axil_awvalid_i   = 2'b10;
    s_axil_awaddr_i[1] = 32'h8000_0040;
    settle();
    tally();
    cyc();
    settle();
    tally();
    chk("wr_awaddr", m_axil_awaddr_o, 32'h8000_0040);
    chk("wr_wstrb", m_axil_wstrb_o, 8'hF0);
    chk("wr_wdata", m_axil_wdata_o, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("wr_awready", s_axil_awready_o, 2'b10);
    chk("wr_wready", s_axil_wready_o, 2'b10);
    cyc();
    s_axil_awvalid_i = 2'b00;
    s_axil_wvalid_i  = 2'b00;
    m_axil_bvalid_i  = 1'b1;
    m_axil_bresp_i   = 2'b10;
    s_axil_bready_i  = 2'b10;
    settle();
    tally();
    chk("wr_bvalid", s_axil_bvalid_o, 2'b10);
    chk("wr_bresp1", s_axil_bresp_o[1], 2'b10);
    chk("wr_bresp0_zero", s_axil_bresp_o[0], 2'b00);
    chk("wr_bready", m_axil_bready_o, 1'b1);
    cyc();
    clear_inputs();
    settle();
    chk("wr_done_all_zero", 64'(all_vr()), 64'd0);
    chk("wr_aw_hs_count", 64'(aw_cnt), 64'd1);
    chk("wr_w_hs_count", 64'(w_cnt), 64'd1);

    // ---- concurrent read port 0 and write port 1, zero-wait slave
    cyc();
    s_axil_arvalid_i   = 2'b01;
    s_axil_araddr_i[0] = 32'h0000_0100;
    s_axil_awvalid_i   = 2'b10;
    s_axil_awaddr_i[1] = 32'h0000_0200;
    s_axil_wvalid_i    = 2'b10;
    s_axil_wdata_i[1]  = 64'h2222;
    s_axil_wstrb_i[1]  = 8'hFF;
    m_axil_arready_i = 1'b1; m_axil_awready_i = 1'b1; m_axil_wready_i = 1'b1;
    m_axil_rvalid_i  = 1'b1; m_axil_bvalid_i  = 1'b1;
    m_axil_rdata_i   = 64'h1111_1111_1111_1111;
    s_axil_rready_i  = 2'b11; s_axil_bready_i = 2'b11;
    settle();
    chk("cc_idle_all_zero", 64'(all_vr()), 64'd0);
    cyc();
    settle();
    chk("cc_arready", s_axil_arready_o, 2'b01);
    chk("cc_awready", s_axil_awready_o, 2'b10);
    chk("cc_wready", s_axil_wready_o, 2'b10);
    cyc();
    s_axil_arvalid_i = 2'b00; s_axil_awvalid_i = 2'b00; s_axil_wvalid_i = 2'b00;
    settle();
    chk("cc_rvalid", s_axil_rvalid_o, 2'b01);
    chk("cc_bvalid", s_axil_bvalid_o, 2'b10);
    chk("cc_rdata0", s_axil_rdata_o[0], 64'h1111_1111_1111_1111);
    chk("cc_rdata1_zero", s_axil_rdata_o[1], 64'd0);
    cyc();
    settle();
    chk("cc_done_all_zero", 64'(all_vr()), 64'd0);
    cyc();
    clear_inputs();

    // ---- AW stalled 10 cycles on port 1 while port 0 also requests
    aw_cnt = 0;
    w_cnt  = 0;
    cyc();
    s_axil_awvalid_i   = 2'b10;
    s_axil_wvalid_i    = 2'b10;
    s_axil_awaddr_i[1] = 32'h0000_2000;
    s_axil_wdata_i[1]  = 64'h3333;
    s_axil_wstrb_i[1]  = 8'h0F;
    m_axil_wready_i    = 1'b1;
    settle();
    tally();
    cyc();
    s_axil_awvalid_i   = 2'b11;
    s_axil_wvalid_i    = 2'b11;
    s_axil_awaddr_i[0] = 32'h0000_3000;
    s_axil_wdata_i[0]  = 64'h4444;
    s_axil_wstrb_i[0]  = 8'hFF;
    settle();
    tally();
    chk("st_wready_first", s_axil_wready_o, 2'b10);
    chk("st_awready_c1", s_axil_awready_o, 2'b00);
    for (int i = 2; i <= 10; i++) begin
      cyc();
      s_axil_wvalid_i = 2'b01;
      settle();
      tally();
      chk($sformatf("st_awvalid_c%0d", i), m_axil_awvalid_o, 1'b1);
      chk($sformatf("st_awaddr_c%0d", i), m_axil_awaddr_o, 32'h0000_2000);
      chk($sformatf("st_awready_c%0d", i), s_axil_awready_o, 2'b00);
      chk($sformatf("st_wvalid_c%0d", i), m_axil_wvalid_o, 1'b0);
    end
    cyc();
    m_axil_awready_i = 1'b1;
    settle();
    tally();
    chk("st_awready_release", s_axil_awready_o, 2'b10);
    cyc();
    s_axil_awvalid_i = 2'b01;
    m_axil_awready_i = 1'b0;
    m_axil_bvalid_i  = 1'b1;
    m_axil_bresp_i   = 2'b00;
    s_axil_bready_i  = 2'b11;
    settle();
    tally();
    chk("st_bvalid", s_axil_bvalid_o, 2'b10);
    chk("st_resp_awready", s_axil_awready_o, 2'b00);
    cyc();
    m_axil_bvalid_i = 1'b0;
    s_axil_bready_i = 2'b00;
    settle();
    chk("st_idle_all_zero", 64'(all_vr()), 64'd0);
    chk("st_aw_hs_count", 64'(aw_cnt), 64'd1);
    chk("st_w_hs_count", 64'(w_cnt), 64'd1);

    // ---- port 0 now wins, then reset lands in W_RESP
    cyc();
    m_axil_awready_i = 1'b1;
    m_axil_wready_i  = 1'b1;
    settle();
    chk("p0_awready", s_axil_awready_o, 2'b01);
    chk("p0_wready", s_axil_wready_o, 2'b01);
    chk("p0_awaddr", m_axil_awaddr_o, 32'h0000_3000);
    cyc();
    s_axil_awvalid_i = 2'b00;
    s_axil_wvalid_i  = 2'b00;
    m_axil_awready_i = 1'b0;
    m_axil_wready_i  = 1'b0;
    m_axil_bvalid_i  = 1'b1;
    s_axil_bready_i  = 2'b00;
    settle();
    chk("p0_bvalid", s_axil_bvalid_o, 2'b01);
    chk("p0_bready_held", m_axil_bready_o, 1'b0);
    cyc();
    reset_i = 1'b1;
    s_axil_bready_i = 2'b01;
    settle();
    chk("mid_reset_all_zero", 64'(all_vr()), 64'd0);
    cyc();
    reset_i = 1'b0;
    clear_inputs();
    settle();
    chk("mid_reset_after_zero", 64'(all_vr()), 64'd0);

    // ---- first post-reset write from port 1
    cyc();
    s_axil_awvalid_i   = 2'b10;
    s_axil_wvalid_i    = 2'b10;
    s_axil_awaddr_i[1] = 32'h0000_4000;
    s_axil_wdata_i[1]  = 64'h5555;
    s_axil_wstrb_i[1]  = 8'hFF;
    m_axil_awready_i   = 1'b1;
    m_axil_wready_i    = 1'b1;
    settle();
    chk("pr_idle_all_zero", 64'(all_vr()), 64'd0);
    cyc();
    settle();
    chk("pr_awready", s_axil_awready_o, 2'b10);
    chk("pr_wready", s_axil_wready_o, 2'b10);
    chk("pr_awaddr", m_axil_awaddr_o, 32'h0000_4000);
    cyc();
    s_axil_awvalid_i = 2'b00;
    s_axil_wvalid_i  = 2'b00;
    m_axil_bvalid_i  = 1'b1;
    m_axil_bresp_i   = 2'b00;
    s_axil_bready_i  = 2'b10;
    settle();
    chk("pr_bvalid", s_axil_bvalid_o, 2'b10);
    chk("pr_bresp", s_axil_bresp_o[1], 2'b00);
    cyc();
    clear_inputs();
    settle();
    chk("pr_done_all_zero", 64'(all_vr()), 64'd0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
